// File: rtl/frame_renderer.sv
// rtl/frame_renderer.sv - per-frame erase/draw pixel sequencer for the 160x120 playfield
module frame_renderer #(
   parameter int         BALL_W        = 2,
   parameter int         BALL_H        = 2,
   parameter int         PADDLE_W      = 13,
   parameter logic [6:0] PADDLE_Y      = 7'd110,
   parameter logic [2:0] BG_COLOUR     = 3'b000,
   parameter logic [2:0] PADDLE_COLOUR = 3'b011
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       frame_tick,
   input  logic [7:0] ball_x,
   input  logic [6:0] ball_y,
   input  logic [2:0] ball_colour,
   input  logic [7:0] paddle_x,
   output logic [7:0] x,
   output logic [6:0] y,
   output logic [2:0] colour,
   output logic       plot,
   output logic       busy,
   output logic       frame_done,
   output logic       overrun
);

   typedef enum logic [2:0] {
      IDLE,
      ERASE_BALL,
      ERASE_PADDLE,
      DRAW_BALL,
      DRAW_PADDLE,
      DONE
   } state_t;

   localparam logic [3:0] BALL_LAST   = 4'(BALL_W * BALL_H - 1);
   localparam logic [3:0] PADDLE_LAST = 4'(PADDLE_W - 1);

   state_t     state;
   state_t     nxt_state;
   logic [3:0] cnt;
   logic [3:0] nxt_cnt;
   logic       accept;

   // "new" set: captured on accept, drawn this frame
   logic [7:0] new_bx;
   logic [6:0] new_by;
   logic [2:0] new_colour;
   logic [7:0] new_px;

   // "old" set: what is currently on screen and must be erased
   logic [7:0] old_bx;
   logic [6:0] old_by;
   logic [7:0] old_px;
   logic       old_valid;

   // pixel selected for the state/counter the FSM moves into next
   logic [7:0] base_x;
   logic [6:0] base_y;
   logic [8:0] off_x;
   logic [7:0] off_y;
   logic [8:0] sum_x;
   logic [7:0] sum_y;
   logic [2:0] pix_colour;
   logic       pix_on;
   logic       pix_plot;

   // Next-state and counter: the counter restarts on every state entry
   always_comb begin
      nxt_state = state;
      nxt_cnt   = cnt + 4'd1;
      accept    = 1'b0;
      case (state)
         IDLE: begin
            nxt_cnt = 4'd0;
            if (frame_tick) begin
               accept    = 1'b1;
               nxt_state = old_valid ? ERASE_BALL : DRAW_BALL;
            end
         end
         ERASE_BALL: begin
            if (cnt == BALL_LAST) begin
               nxt_state = ERASE_PADDLE;
               nxt_cnt   = 4'd0;
            end
         end
         ERASE_PADDLE: begin
            if (cnt == PADDLE_LAST) begin
               nxt_state = DRAW_BALL;
               nxt_cnt   = 4'd0;
            end
         end
         DRAW_BALL: begin
            if (cnt == BALL_LAST) begin
               nxt_state = DRAW_PADDLE;
               nxt_cnt   = 4'd0;
            end
         end
         DRAW_PADDLE: begin
            if (cnt == PADDLE_LAST) begin
               nxt_state = DONE;
               nxt_cnt   = 4'd0;
            end
         end
         DONE: begin
            nxt_state = IDLE;
            nxt_cnt   = 4'd0;
         end
         default: begin
            nxt_state = IDLE;
            nxt_cnt   = 4'd0;
         end
      endcase
   end

   // Pixel address/colour for the upcoming cycle; on accept the new set is
   // still on the inputs, so DRAW_BALL reads them directly
   always_comb begin
      base_x     = 8'd0;
      base_y     = 7'd0;
      off_x      = 9'd0;
      off_y      = 8'd0;
      pix_colour = 3'b000;
      pix_on     = 1'b0;
      case (nxt_state)
         ERASE_BALL: begin
            pix_on     = 1'b1;
            base_x     = old_bx;
            base_y     = old_by;
            off_x      = 9'(int'(nxt_cnt) % BALL_W);
            off_y      = 8'(int'(nxt_cnt) / BALL_W);
            pix_colour = BG_COLOUR;
         end
         ERASE_PADDLE: begin
            pix_on     = 1'b1;
            base_x     = old_px;
            base_y     = PADDLE_Y;
            off_x      = 9'(nxt_cnt);
            pix_colour = BG_COLOUR;
         end
         DRAW_BALL: begin
            pix_on     = 1'b1;
            base_x     = accept ? ball_x : new_bx;
            base_y     = accept ? ball_y : new_by;
            off_x      = 9'(int'(nxt_cnt) % BALL_W);
            off_y      = 8'(int'(nxt_cnt) / BALL_W);
            pix_colour = accept ? ball_colour : new_colour;
         end
         DRAW_PADDLE: begin
            pix_on     = 1'b1;
            base_x     = new_px;
            base_y     = PADDLE_Y;
            off_x      = 9'(nxt_cnt);
            pix_colour = PADDLE_COLOUR;
         end
         default: begin
            pix_on = 1'b0;
         end
      endcase
      sum_x    = {1'b0, base_x} + off_x;
      sum_y    = {1'b0, base_y} + off_y;
      pix_plot = pix_on && (sum_x < 9'd160) && (sum_y < 8'd120);
   end

   // FSM state, position sets and registered outputs
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state      <= IDLE;
         cnt        <= 4'd0;
         new_bx     <= 8'd0;
         new_by     <= 7'd0;
         new_colour <= 3'b000;
         new_px     <= 8'd0;
         old_bx     <= 8'd0;
         old_by     <= 7'd0;
         old_px     <= 8'd0;
         old_valid  <= 1'b0;
         x          <= 8'd0;
         y          <= 7'd0;
         colour     <= 3'b000;
         plot       <= 1'b0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         state <= nxt_state;
         cnt   <= nxt_cnt;
         if (accept) begin
            new_bx     <= ball_x;
            new_by     <= ball_y;
            new_colour <= ball_colour;
            new_px     <= paddle_x;
         end
         if (state == DONE) begin
            old_bx    <= new_bx;
            old_by    <= new_by;
            old_px    <= new_px;
            old_valid <= 1'b1;
         end
         x          <= pix_on ? sum_x[7:0] : 8'd0;
         y          <= pix_on ? sum_y[6:0] : 7'd0;
         colour     <= pix_on ? pix_colour : 3'b000;
         plot       <= pix_plot;
         busy       <= (nxt_state != IDLE);
         frame_done <= (nxt_state == DONE);
         overrun    <= frame_tick && (state != IDLE);
      end
   end

endmodule

// File: tb/tb_frame_renderer.sv
// tb/tb_frame_renderer.sv - self-checking bench for frame_renderer
module tb_frame_renderer;

   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic       frame_tick = 1'b0;
   logic [7:0] ball_x = 8'd0;
   logic [6:0] ball_y = 7'd0;
   logic [2:0] ball_colour = 3'b000;
   logic [7:0] paddle_x = 8'd0;
   logic [7:0] x;
   logic [6:0] y;
   logic [2:0] colour;
   logic       plot;
   logic       busy;
   logic       frame_done;
   logic       overrun;

   always #5 clk = ~clk;

   frame_renderer dut (
      .clk        (clk),
      .resetn     (resetn),
      .frame_tick (frame_tick),
      .ball_x     (ball_x),
      .ball_y     (ball_y),
      .ball_colour(ball_colour),
      .paddle_x   (paddle_x),
      .x          (x),
      .y          (y),
      .colour     (colour),
      .plot       (plot),
      .busy       (busy),
      .frame_done (frame_done),
      .overrun    (overrun)
   );

   int vectors = 0;
   int miscompares = 0;

   typedef struct {
      int       px;
      int       py;
      logic [2:0] c;
   } pix_t;

   pix_t exp_q[$];

   // reference screen state: what the previous completed frame left drawn
   bit m_valid = 1'b0;
   int m_bx = 0;
   int m_by = 0;
   int m_px = 0;

   typedef struct {
      logic [7:0] bx;
      logic [6:0] by;
      logic [2:0] bc;
      logic [7:0] px;
      int         ovr_at;
      bit         tick_in_done;
      bit         toggle;
      int         exp_plots;
      int         exp_len;
   } vec_t;

   vec_t tbl[6];

   task automatic chk(input string name, input int act, input int expv);
      vectors++;
      if (act != expv) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d", name, act, expv);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic add_ball(input int bx, input int by, input logic [2:0] c);
      for (int r = 0; r < 2; r++)
         for (int col = 0; col < 2; col++)
            exp_q.push_back('{bx + col, by + r, c});
   endtask

   task automatic add_paddle(input int px, input logic [2:0] c);
      for (int k = 0; k < 13; k++)
         exp_q.push_back('{px + k, 110, c});
   endtask

   task automatic run_frame(input logic [7:0] bx, input logic [6:0] by, input logic [2:0] bc,
                            input logic [7:0] px, input int ovr_at, input bit tick_in_done,
                            input bit toggle, output int plots, output int len);
      bit done_seen;
      int ep;
      exp_q.delete();
      if (m_valid) begin
         add_ball(m_bx, m_by, 3'b000);
         add_paddle(m_px, 3'b000);
      end
      add_ball(int'(bx), int'(by), bc);
      add_paddle(int'(px), 3'b011);
      m_valid = 1'b1;
      m_bx = int'(bx);
      m_by = int'(by);
      m_px = int'(px);

      ball_x = bx;
      ball_y = by;
      ball_colour = bc;
      paddle_x = px;
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      done_seen = 1'b0;
      plots = 0;
      len = -1;
      for (int i = 0; i < 60 && !done_seen; i++) begin
         chk($sformatf("overrun c%0d", i), int'(overrun), (ovr_at >= 0 && i == ovr_at + 1) ? 1 : 0);
         chk($sformatf("busy c%0d", i), int'(busy), 1);
         if (frame_done) begin
            done_seen = 1'b1;
            len = i;
            chk("plot in done", int'(plot), 0);
            chk("frame length", i, exp_q.size());
            frame_tick = tick_in_done;
         end else begin
            if (plot) plots++;
            if (i < exp_q.size()) begin
               ep = (exp_q[i].px < 160 && exp_q[i].py < 120) ? 1 : 0;
               chk($sformatf("x c%0d", i), int'(x), exp_q[i].px % 256);
               chk($sformatf("y c%0d", i), int'(y), exp_q[i].py % 128);
               chk($sformatf("plot c%0d", i), int'(plot), ep);
               if (ep == 1) chk($sformatf("colour c%0d", i), int'(colour), int'(exp_q[i].c));
            end else begin
               chk($sformatf("extra pixel c%0d", i), 1, 0);
            end
            frame_tick = (i == ovr_at);
            if (toggle) begin
               ball_x = 8'($urandom);
               ball_y = 7'($urandom);
               ball_colour = 3'($urandom);
               paddle_x = 8'($urandom);
            end
         end
         step();
      end
      frame_tick = 1'b0;
      if (!done_seen) chk("frame_done timeout", 0, 1);
      chk("busy after done", int'(busy), 0);
      chk("frame_done single", int'(frame_done), 0);
      chk("overrun after done", int'(overrun), tick_in_done ? 1 : 0);
      step();
      chk("no extra frame", int'(busy), 0);
      chk("idle plot", int'(plot), 0);
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, " x"}, int'(x), 0);
      chk({tag, " y"}, int'(y), 0);
      chk({tag, " colour"}, int'(colour), 0);
      chk({tag, " plot"}, int'(plot), 0);
      chk({tag, " busy"}, int'(busy), 0);
      chk({tag, " frame_done"}, int'(frame_done), 0);
      chk({tag, " overrun"}, int'(overrun), 0);
   endtask

   int plots;
   int len;

   initial begin
      //           bx    by    bc      px   ovr td tg plots len
      tbl[0] = '{8'd60, 7'd60, 3'b100, 8'd74, -1, 0, 0, 17, 17};
      tbl[1] = '{8'd62, 7'd58, 3'b101, 8'd75, -1, 0, 0, 34, 34};
      tbl[2] = '{8'd159, 7'd119, 3'b110, 8'd20, -1, 0, 0, 31, 34};
      tbl[3] = '{8'd10, 7'd20, 3'b001, 8'd150, -1, 0, 0, 28, 34};
      tbl[4] = '{8'd0, 7'd0, 3'b111, 8'd0, 5, 0, 0, 31, 34};
      tbl[5] = '{8'd100, 7'd100, 3'b010, 8'd50, -1, 1, 1, 34, 34};

      resetn = 1'b0;
      step();
      step();
      check_all_zero("reset");
      resetn = 1'b1;
      step();
      step();
      check_all_zero("idle");

      for (int t = 0; t < 6; t++) begin
         run_frame(tbl[t].bx, tbl[t].by, tbl[t].bc, tbl[t].px, tbl[t].ovr_at,
                   tbl[t].tick_in_done, tbl[t].toggle, plots, len);
         chk($sformatf("tbl%0d plots", t), plots, tbl[t].exp_plots);
         chk($sformatf("tbl%0d length", t), len, tbl[t].exp_len);
      end

      // reset pulse during DRAW_PADDLE of a full frame
      ball_x = 8'd30;
      ball_y = 7'd40;
      ball_colour = 3'b101;
      paddle_x = 8'd90;
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      repeat (24) step();
      chk("busy before abort", int'(busy), 1);
      chk("plot before abort", int'(plot), 1);
      resetn = 1'b0;
      #1;
      check_all_zero("abort");
      step();
      resetn = 1'b1;
      m_valid = 1'b0;
      step();
      check_all_zero("post abort");
      run_frame(8'd5, 7'd6, 3'b011, 8'd7, -1, 0, 0, plots, len);
      chk("post abort plots", plots, 17);
      chk("post abort length", len, 17);

      // randomized frames against the reference screen model
      for (int r = 0; r < 20; r++) begin
         run_frame(8'($urandom), 7'($urandom), 3'($urandom), 8'($urandom),
                   ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 30)) : -1,
                   1'($urandom), 1'($urandom), plots, len);
         chk($sformatf("rand%0d length", r), len, 34);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
